// File: rtl/bram_preload_ctrl.sv
// Preload sequencer for one 36K TDP RAM/FIFO tile: streams words onto the PL_* bus,
// optionally reads each word back and flags the first mismatching address.
module bram_preload_ctrl #(
  parameter int RD_LAT = 2,
  parameter int ADDR_W = 10
) (
  input  logic              CLK_i,
  input  logic              RESET_i,
  input  logic              START_i,
  input  logic              ABORT_i,
  input  logic              VERIFY_i,
  input  logic [19:0]       RAM_ID_i,
  input  logic [ADDR_W-1:0] BASE_ADDR_i,
  input  logic [ADDR_W:0]   WORD_COUNT_i,
  input  logic              DIN_VALID_i,
  input  logic [35:0]       DIN_DATA_i,
  output logic              DIN_READY_o,
  output logic              PL_INIT_o,
  output logic              PL_ENA_o,
  output logic              PL_REN_o,
  output logic [1:0]        PL_WEN_o,
  output logic [31:0]       PL_ADDR_o,
  output logic [35:0]       PL_DATA_o,
  input  logic [35:0]       PL_DATA_i,
  output logic              BUSY_o,
  output logic              DONE_o,
  output logic              ERR_o,
  output logic [ADDR_W-1:0] ERR_ADDR_o,
  output logic [2:0]        DBG_STATE_o
);

  // DIN stream: a word transfers on every clock edge where DIN_VALID_i && DIN_READY_o;
  // DIN_READY_o never depends on DIN_VALID_i, and an offered word may be held indefinitely.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_WAIT  = 3'd4,
    S_CHECK = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  localparam logic [2:0]        WAIT_LAST = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [19:0]         ram_id_q, ram_id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                verify_q, verify_d;
  logic [35:0]         cmp_q, cmp_d;
  logic [2:0]          wait_q, wait_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic                do_adv;

  always_ff @(posedge CLK_i) begin
    if (RESET_i) begin
      state_q    <= S_IDLE;
      ram_id_q   <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      verify_q   <= 1'b0;
      cmp_q      <= '0;
      wait_q     <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      ram_id_q   <= ram_id_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      verify_q   <= verify_d;
      cmp_q      <= cmp_d;
      wait_q     <= wait_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ram_id_d   = ram_id_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    verify_d   = verify_q;
    cmp_d      = cmp_q;
    wait_d     = wait_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    do_adv     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START_i && !ABORT_i) begin
          ram_id_d   = RAM_ID_i;
          addr_d     = BASE_ADDR_i;
          cnt_d      = WORD_COUNT_i;
          verify_d   = VERIFY_i;
          err_d      = 1'b0;
          err_addr_d = '0;
          state_d    = S_INIT;
        end
      end
      S_INIT: begin
        state_d = (cnt_q == '0) ? S_FIN : S_WRITE;
      end
      S_WRITE: begin
        if (DIN_VALID_i) begin
          cmp_d = DIN_DATA_i;
          if (verify_q) state_d = S_READ;
          else          do_adv  = 1'b1;
        end
      end
      S_READ: begin
        wait_d  = '0;
        state_d = (RD_LAT == 1) ? S_CHECK : S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = S_CHECK;
        else                     wait_d  = wait_q + 3'd1;
      end
      S_CHECK: begin
        // Only the first mismatch of a load is recorded.
        if ((PL_DATA_i != cmp_q) && !err_q) begin
          err_d      = 1'b1;
          err_addr_d = addr_q;
        end
        do_adv = 1'b1;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (do_adv) begin
      addr_d  = addr_q + ADDR_ONE;
      cnt_d   = cnt_q - CNT_ONE;
      state_d = (cnt_q == CNT_ONE) ? S_FIN : S_WRITE;
    end

    // Abort leaves error status intact so the loader can still inspect it.
    if (ABORT_i) begin
      state_d    = S_IDLE;
      err_d      = err_q;
      err_addr_d = err_addr_q;
    end
  end

  always_comb begin
    DIN_READY_o = (state_q == S_WRITE);
    PL_INIT_o   = (state_q == S_INIT);
    PL_REN_o    = (state_q == S_READ);
    PL_ENA_o    = (state_q == S_INIT) || (state_q == S_WRITE) || (state_q == S_READ) ||
                  (state_q == S_WAIT) || (state_q == S_CHECK);
    PL_WEN_o    = 2'b00;
    PL_DATA_o   = '0;
    if ((state_q == S_WRITE) && DIN_VALID_i) begin
      PL_WEN_o  = 2'b11;
      PL_DATA_o = DIN_DATA_i;
    end
    PL_ADDR_o   = (state_q == S_IDLE) ? 32'd0 : {ram_id_q, 12'(addr_q)};
    BUSY_o      = (state_q != S_IDLE);
    DONE_o      = (state_q == S_FIN);
    ERR_o       = err_q;
    ERR_ADDR_o  = err_addr_q;
    DBG_STATE_o = state_q;
  end

endmodule

// File: tb/tb_bram_preload_ctrl.sv
// Bench for bram_preload_ctrl: tile memory model with programmable read corruption,
// bus monitor, and a word-level reference for addresses, data, timing and error status.
module tb_bram_preload_ctrl;
  localparam int RD_LAT = 2;
  localparam int ADDR_W = 10;
  localparam logic [35:0] CORRUPT_XOR = 36'h8_0000_0001;

  logic              clk = 1'b0;
  logic              RESET_i, START_i, ABORT_i, VERIFY_i;
  logic [19:0]       RAM_ID_i;
  logic [ADDR_W-1:0] BASE_ADDR_i;
  logic [ADDR_W:0]   WORD_COUNT_i;
  logic              DIN_VALID_i;
  logic [35:0]       DIN_DATA_i;
  logic              DIN_READY_o, PL_INIT_o, PL_ENA_o, PL_REN_o;
  logic [1:0]        PL_WEN_o;
  logic [31:0]       PL_ADDR_o;
  logic [35:0]       PL_DATA_o, PL_DATA_i;
  logic              BUSY_o, DONE_o, ERR_o;
  logic [ADDR_W-1:0] ERR_ADDR_o;
  logic [2:0]        DBG_STATE_o;

  bram_preload_ctrl #(.RD_LAT(RD_LAT), .ADDR_W(ADDR_W)) dut (
    .CLK_i(clk), .RESET_i(RESET_i), .START_i(START_i), .ABORT_i(ABORT_i),
    .VERIFY_i(VERIFY_i), .RAM_ID_i(RAM_ID_i), .BASE_ADDR_i(BASE_ADDR_i),
    .WORD_COUNT_i(WORD_COUNT_i), .DIN_VALID_i(DIN_VALID_i), .DIN_DATA_i(DIN_DATA_i),
    .DIN_READY_o(DIN_READY_o), .PL_INIT_o(PL_INIT_o), .PL_ENA_o(PL_ENA_o),
    .PL_REN_o(PL_REN_o), .PL_WEN_o(PL_WEN_o), .PL_ADDR_o(PL_ADDR_o),
    .PL_DATA_o(PL_DATA_o), .PL_DATA_i(PL_DATA_i), .BUSY_o(BUSY_o), .DONE_o(DONE_o),
    .ERR_o(ERR_o), .ERR_ADDR_o(ERR_ADDR_o), .DBG_STATE_o(DBG_STATE_o)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- tile model and bus monitor ----------------
  logic [35:0] mem [1024];
  bit          corrupt [1024];
  logic [35:0] din_q[$];
  int          valid_mode = 0;      // 0: never valid, 1: always valid, 2: random stalls
  int          wr_cyc_q[$];
  logic [31:0] wr_addr_q[$];
  logic [35:0] wr_data_q[$];
  logic [1:0]  wr_wen_q[$];
  int          ren_cyc_q[$];
  logic [31:0] ren_addr_q[$];
  int          done_cyc_q[$];
  int          rd_due_q[$];
  logic [9:0]  rd_a_q[$];
  logic [9:0]  mon_a;

  always @(negedge clk) begin
    if (DIN_VALID_i && DIN_READY_o && din_q.size() > 0) void'(din_q.pop_front());
    if (PL_WEN_o != 2'b00) begin
      wr_cyc_q.push_back(cyc);
      wr_addr_q.push_back(PL_ADDR_o);
      wr_data_q.push_back(PL_DATA_o);
      wr_wen_q.push_back(PL_WEN_o);
      if (PL_WEN_o == 2'b11) mem[PL_ADDR_o[9:0]] = PL_DATA_o;
    end
    if (DONE_o) done_cyc_q.push_back(cyc);
    PL_DATA_i = 36'({$urandom(), $urandom()});
    while (rd_due_q.size() > 0 && rd_due_q[0] < cyc) begin
      void'(rd_due_q.pop_front());
      void'(rd_a_q.pop_front());
    end
    if (rd_due_q.size() > 0 && rd_due_q[0] == cyc) begin
      void'(rd_due_q.pop_front());
      mon_a = rd_a_q.pop_front();
      PL_DATA_i = mem[mon_a] ^ (corrupt[mon_a] ? CORRUPT_XOR : 36'h0);
    end
    if (PL_REN_o) begin
      ren_cyc_q.push_back(cyc);
      ren_addr_q.push_back(PL_ADDR_o);
      rd_due_q.push_back(cyc + RD_LAT);
      rd_a_q.push_back(PL_ADDR_o[9:0]);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (din_q.size() > 0 && (valid_mode == 1 || (valid_mode == 2 && $urandom_range(0, 3) != 0))) begin
      DIN_VALID_i = 1'b1;
      DIN_DATA_i  = din_q[0];
    end else begin
      DIN_VALID_i = 1'b0;
      DIN_DATA_i  = 36'($urandom());
    end
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ctrl"}, {DIN_READY_o, PL_INIT_o, PL_ENA_o, PL_REN_o, PL_WEN_o, BUSY_o, DONE_o, ERR_o}, 64'd0);
    chk({tag, "_addr"}, PL_ADDR_o, 64'd0);
    chk({tag, "_data"}, PL_DATA_o, 64'd0);
    chk({tag, "_erraddr"}, ERR_ADDR_o, 64'd0);
  endtask

  task automatic clear_logs();
    wr_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete(); wr_wen_q.delete();
    ren_cyc_q.delete(); ren_addr_q.delete(); done_cyc_q.delete();
  endtask

  task automatic clear_corrupt();
    for (int i = 0; i < 1024; i++) corrupt[i] = 1'b0;
  endtask

  // Full load with word-level expectations computed from the load parameters.
  task automatic run_load(input logic [19:0] rid, input int base, input int cnt,
                          input bit ver, input int vmode, input bit seq_words);
    logic [31:0] exp_addr_q[$];
    logic [35:0] exp_data_q[$];
    logic [35:0] w;
    logic [9:0]  a;
    logic        exp_err;
    logic [9:0]  exp_err_addr;
    int c0, waited, interval, done_exp, n;
    bit got_done;
    exp_err = 1'b0;
    exp_err_addr = '0;
    clear_logs();
    din_q.delete();
    for (int k = 0; k < cnt; k++) begin
      a = 10'((base + k) % 1024);
      w = seq_words ? 36'(k + 1) : 36'({$urandom(), $urandom()});
      exp_addr_q.push_back({rid, 2'b00, a});
      exp_data_q.push_back(w);
      din_q.push_back(w);
      if (ver && corrupt[a] && !exp_err) begin
        exp_err = 1'b1;
        exp_err_addr = a;
      end
    end
    interval = ver ? (RD_LAT + 2) : 1;
    valid_mode = vmode;
    step();
    START_i = 1'b1; RAM_ID_i = rid; BASE_ADDR_i = 10'(base);
    WORD_COUNT_i = 11'(cnt); VERIFY_i = ver;
    c0 = cyc;
    step();
    START_i = 1'b0; RAM_ID_i = 20'($urandom()); BASE_ADDR_i = 10'($urandom());
    WORD_COUNT_i = 11'($urandom()); VERIFY_i = 1'($urandom());
    chk("init_state", {PL_INIT_o, PL_ENA_o, BUSY_o, PL_WEN_o}, 64'b11100);
    waited = 0;
    got_done = 1'b0;
    while (!got_done && waited < 200 + cnt * 40) begin
      step();
      waited++;
      if (DONE_o) got_done = 1'b1;
    end
    chk("done_seen", got_done, 64'd1);
    step();
    chk("busy_low_after_done", {BUSY_o, DONE_o}, 64'd0);
    chk("done_pulses", done_cyc_q.size(), 64'd1);
    chk("wr_count", wr_addr_q.size(), 64'(cnt));
    n = (wr_addr_q.size() < cnt) ? wr_addr_q.size() : cnt;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("wr_addr[%0d]", k), wr_addr_q[k], exp_addr_q[k]);
      chk($sformatf("wr_data[%0d]", k), wr_data_q[k], exp_data_q[k]);
      chk($sformatf("wr_wen[%0d]", k), wr_wen_q[k], 64'd3);
      if (vmode == 1)
        chk($sformatf("wr_cyc[%0d]", k), wr_cyc_q[k], 64'(c0 + 2 + k * interval));
      else if (k > 0)
        chk($sformatf("wr_gap[%0d]", k), (wr_cyc_q[k] - wr_cyc_q[k-1]) >= interval, 64'd1);
    end
    chk("ren_count", ren_cyc_q.size(), ver ? 64'(cnt) : 64'd0);
    if (ver) begin
      for (int k = 0; k < n && k < ren_cyc_q.size(); k++) begin
        chk($sformatf("ren_cyc[%0d]", k), ren_cyc_q[k], 64'(wr_cyc_q[k] + 1));
        chk($sformatf("ren_addr[%0d]", k), ren_addr_q[k], exp_addr_q[k]);
      end
    end
    if (cnt == 0) done_exp = c0 + 2;
    else if (ver && ren_cyc_q.size() > 0) done_exp = ren_cyc_q[ren_cyc_q.size()-1] + RD_LAT + 1;
    else if (wr_cyc_q.size() > 0) done_exp = wr_cyc_q[wr_cyc_q.size()-1] + 1;
    else done_exp = -1;
    if (done_cyc_q.size() > 0) chk("done_cyc", done_cyc_q[0], 64'(done_exp));
    chk("err", ERR_o, 64'(exp_err));
    chk("err_addr", ERR_ADDR_o, 64'(exp_err_addr));
    din_q.delete();
    valid_mode = 0;
  endtask

  // ---------------- directed + random sequence ----------------
  int c0, n, renseen;
  logic [19:0] rid;
  int base, cnt;

  initial begin
    RESET_i = 1'b1; START_i = 1'b0; ABORT_i = 1'b0; VERIFY_i = 1'b0;
    RAM_ID_i = '0; BASE_ADDR_i = '0; WORD_COUNT_i = '0;
    DIN_VALID_i = 1'b0; DIN_DATA_i = '0; PL_DATA_i = '0;
    clear_corrupt();
    repeat (3) step();
    chk_idle("reset");
    chk("reset_state", DBG_STATE_o, 64'd0);
    RESET_i = 1'b0;
    step();

    // basic stream, address wrap, count zero
    run_load(20'h12345, 0, 4, 1'b0, 1, 1'b1);
    run_load(20'hABCDE, 1022, 3, 1'b0, 1, 1'b0);
    if (wr_addr_q.size() == 3) begin
      chk("wrap_addr0", wr_addr_q[0], 64'hABCDE3FE);
      chk("wrap_addr1", wr_addr_q[1], 64'hABCDE3FF);
      chk("wrap_addr2", wr_addr_q[2], 64'hABCDE000);
    end
    run_load(20'h00001, 7, 0, 1'b1, 1, 1'b0);

    // verify with corruption at 5 then 6, then a clean verify that must clear ERR
    clear_corrupt();
    corrupt[5] = 1'b1;
    corrupt[6] = 1'b1;
    run_load(20'h0F0F0, 4, 4, 1'b1, 1, 1'b0);
    clear_corrupt();
    run_load(20'h55555, 0, 2, 1'b1, 1, 1'b0);

    // stall, ignored START, then ABORT with a word accepted in the abort cycle
    clear_logs();
    din_q.delete();
    for (int k = 0; k < 8; k++) din_q.push_back(36'(100 + k));
    valid_mode = 1;
    step();
    START_i = 1'b1; RAM_ID_i = 20'h00042; BASE_ADDR_i = 10'd200; WORD_COUNT_i = 11'd8; VERIFY_i = 1'b0;
    c0 = cyc;
    step();
    START_i = 1'b0;
    step();
    step();
    valid_mode = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      START_i = (k == 1);
      BASE_ADDR_i = 10'd900;
      chk($sformatf("stall_wen[%0d]", k), {PL_WEN_o, DIN_READY_o, BUSY_o}, 64'b0011);
    end
    valid_mode = 1;
    step();
    START_i = 1'b0;
    ABORT_i = 1'b1;
    chk("abort_cycle_wen", PL_WEN_o, 64'd3);
    chk("abort_cycle_addr", PL_ADDR_o, {20'h00042, 12'd202});
    step();
    ABORT_i = 1'b0;
    chk_idle("after_abort");
    step();
    step();
    chk("abort_wr_count", wr_addr_q.size(), 64'd3);
    chk("abort_no_done", done_cyc_q.size(), 64'd0);
    din_q.delete();
    valid_mode = 0;

    // START together with ABORT in IDLE does not start
    step();
    START_i = 1'b1; ABORT_i = 1'b1; WORD_COUNT_i = 11'd4;
    step();
    START_i = 1'b0; ABORT_i = 1'b0;
    chk("start_abort_idle", BUSY_o, 64'd0);

    // reset while waiting for read data; ERR already set by the first word
    clear_corrupt();
    corrupt[100] = 1'b1;
    clear_logs();
    for (int k = 0; k < 3; k++) din_q.push_back(36'({$urandom(), $urandom()}));
    valid_mode = 1;
    step();
    START_i = 1'b1; RAM_ID_i = 20'h77777; BASE_ADDR_i = 10'd100; WORD_COUNT_i = 11'd3; VERIFY_i = 1'b1;
    step();
    START_i = 1'b0;
    n = 0;
    renseen = 0;
    while (renseen < 2 && n < 100) begin
      step();
      n++;
      if (PL_REN_o) renseen++;
    end
    chk("rst_reach_second_read", renseen, 64'd2);
    chk("rst_err_before", {ERR_o, ERR_ADDR_o}, {1'b1, 10'd100});
    step();
    chk("rst_in_wait", {PL_ENA_o, PL_REN_o, PL_WEN_o, BUSY_o}, 64'b10001);
    RESET_i = 1'b1;
    step();
    RESET_i = 1'b0;
    chk_idle("rst_mid_load");
    din_q.delete();
    valid_mode = 0;
    clear_corrupt();
    step();

    // randomized loads, including stalls, wrap and corruption
    for (int it = 0; it < 8; it++) begin
      clear_corrupt();
      rid  = 20'($urandom());
      base = (it == 0) ? 1015 : $urandom_range(0, 1023);
      cnt  = $urandom_range(1, 24);
      if ($urandom_range(0, 1) == 1) corrupt[(base + $urandom_range(0, cnt - 1)) % 1024] = 1'b1;
      if ($urandom_range(0, 1) == 1) corrupt[(base + $urandom_range(0, cnt - 1)) % 1024] = 1'b1;
      run_load(rid, base, cnt, 1'($urandom_range(0, 1)), $urandom_range(1, 2), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
